// File: rtl/phy_cfg_pkg.sv
// Shared definitions for the PHY bring-up sequencer: FSM encodings, MII register map
// and the masked readback comparison.
package phy_cfg_pkg;

   localparam logic [3:0] ST_IDLE         = 4'd0;
   localparam logic [3:0] ST_ISSUE_WR     = 4'd1;
   localparam logic [3:0] ST_WAIT_WR_ACK  = 4'd2;
   localparam logic [3:0] ST_WAIT_WR_DONE = 4'd3;
   localparam logic [3:0] ST_ISSUE_RD     = 4'd4;
   localparam logic [3:0] ST_WAIT_RD_ACK  = 4'd5;
   localparam logic [3:0] ST_WAIT_RD_DONE = 4'd6;
   localparam logic [3:0] ST_CHECK        = 4'd7;
   localparam logic [3:0] ST_NEXT         = 4'd8;
   localparam logic [3:0] ST_DONE         = 4'd9;
   localparam logic [3:0] ST_FAIL         = 4'd10;

   localparam logic [4:0] MII_BMCR = 5'h00;
   localparam logic [4:0] MII_BMSR = 5'h01;

   localparam int BMCR_RESET      = 15;
   localparam int BMCR_LOOPBACK   = 14;
   localparam int BMCR_SPEED_LSB  = 13;
   localparam int BMCR_ANEG_EN    = 12;
   localparam int BMCR_POWER_DOWN = 11;
   localparam int BMCR_ISOLATE    = 10;
   localparam int BMCR_RESTART_AN = 9;
   localparam int BMCR_DUPLEX     = 8;
   localparam int BMCR_SPEED_MSB  = 6;

   // Autoneg enable + full duplex
   localparam logic [15:0] BMCR_DEFAULT = 16'h1100;

   function automatic logic masked_match(input logic [15:0] got,
                                         input logic [15:0] exp,
                                         input logic [15:0] mask);
      return ((got ^ exp) & mask) == 16'h0000;
   endfunction

endpackage

// File: rtl/mdio_wait_timer.sv
// Per-wait-state watchdog: cleared on load, counts while enabled, flags expiry
// on the TIMEOUT-th cycle spent waiting.
module mdio_wait_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_reg <= '0;
      else if (load)
         count_reg <= '0;
      else if (en && !expired)
         count_reg <= count_reg + CW'(1);
   end

   assign expired = en && (count_reg == LAST);

endmodule

// File: rtl/phy_conf_seq.sv
// PHY bring-up sequencer: walks a parameter table of MDIO writes over a range of
// PHY addresses, optionally verifying each write by masked readback with retries.
module phy_conf_seq
   import phy_cfg_pkg::*;
#(
   parameter int                   NUM_PHY   = 1,
   parameter logic [4:0]           PHY_BASE  = 5'h0F,
   parameter int                   NUM_WR    = 2,
   parameter logic [NUM_WR*5-1:0]  CFG_REG   = {MII_BMCR, MII_BMCR},
   parameter logic [NUM_WR*16-1:0] CFG_DATA  = {BMCR_DEFAULT, BMCR_DEFAULT},
   parameter logic [NUM_WR*16-1:0] CFG_MASK  = {16'hFFFF, 16'hFFFF},
   parameter bit                   VERIFY    = 1'b1,
   parameter int                   MAX_RETRY = 3,
   parameter int                   TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_conf,
   input  logic        busy,
   input  logic [15:0] rd_data,
   output logic [4:0]  phy_add_o,
   output logic [4:0]  reg_add,
   output logic [15:0] wr_data,
   output logic        wren,
   output logic        rden,
   output logic        active,
   output logic        done,
   output logic        error,
   output logic [4:0]  err_phy,
   output logic [7:0]  err_idx
);
   localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam int PHY_W = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TBL_N = 1 << IDX_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WR - 1);
   localparam logic [PHY_W-1:0] PHY_LAST = PHY_W'(NUM_PHY - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

   logic [3:0]       state_reg, state_next;
   logic             start_d_reg;
   logic [PHY_W-1:0] phy_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [RTY_W-1:0] retry_reg;
   logic [15:0]      rd_cap_reg;

   // Table padded to a power of two so the entry index is exactly IDX_W bits wide
   logic [4:0]  tbl_reg  [TBL_N];
   logic [15:0] tbl_data [TBL_N];
   logic [15:0] tbl_mask [TBL_N];

   for (genvar gi = 0; gi < TBL_N; gi++) begin : g_tbl
      if (gi < NUM_WR) begin : g_used
         assign tbl_reg[gi]  = CFG_REG[gi*5 +: 5];
         assign tbl_data[gi] = CFG_DATA[gi*16 +: 16];
         assign tbl_mask[gi] = CFG_MASK[gi*16 +: 16];
      end else begin : g_pad
         assign tbl_reg[gi]  = '0;
         assign tbl_data[gi] = '0;
         assign tbl_mask[gi] = '0;
      end
   end

   logic       start_edge, last_entry, rd_ok, in_wait, tmr_load, tmr_expired;
   logic [4:0] cur_phy;

   assign start_edge = start_conf && !start_d_reg;
   assign last_entry = (idx_reg == IDX_LAST) && (phy_reg == PHY_LAST);
   assign rd_ok      = masked_match(rd_cap_reg, tbl_data[idx_reg], tbl_mask[idx_reg]);
   assign cur_phy    = PHY_BASE + 5'(phy_reg);
   assign in_wait    = (state_reg == ST_WAIT_WR_ACK) || (state_reg == ST_WAIT_WR_DONE) ||
                       (state_reg == ST_WAIT_RD_ACK) || (state_reg == ST_WAIT_RD_DONE);
   assign tmr_load   = (state_next != state_reg);

   mdio_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (tmr_load),
      .en      (in_wait),
      .expired (tmr_expired)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_FAIL:
            if (start_edge) state_next = ST_ISSUE_WR;
         ST_ISSUE_WR:
            if (!busy) state_next = ST_WAIT_WR_ACK;
         ST_WAIT_WR_ACK:
            if (busy)             state_next = ST_WAIT_WR_DONE;
            else if (tmr_expired) state_next = ST_FAIL;
         ST_WAIT_WR_DONE:
            if (!busy)            state_next = VERIFY ? ST_ISSUE_RD : ST_NEXT;
            else if (tmr_expired) state_next = ST_FAIL;
         ST_ISSUE_RD:
            state_next = ST_WAIT_RD_ACK;
         ST_WAIT_RD_ACK:
            if (busy)             state_next = ST_WAIT_RD_DONE;
            else if (tmr_expired) state_next = ST_FAIL;
         ST_WAIT_RD_DONE:
            if (!busy)            state_next = ST_CHECK;
            else if (tmr_expired) state_next = ST_FAIL;
         ST_CHECK:
            if (rd_ok)                    state_next = ST_NEXT;
            else if (retry_reg < RTY_MAX) state_next = ST_ISSUE_WR;
            else                          state_next = ST_FAIL;
         ST_NEXT:
            state_next = last_entry ? ST_DONE : ST_ISSUE_WR;
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         start_d_reg <= 1'b0;
         phy_reg     <= '0;
         idx_reg     <= '0;
         retry_reg   <= '0;
         rd_cap_reg  <= '0;
         phy_add_o   <= '0;
         reg_add     <= '0;
         wr_data     <= '0;
         wren        <= 1'b0;
         rden        <= 1'b0;
         active      <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_phy     <= '0;
         err_idx     <= '0;
      end else begin
         state_reg   <= state_next;
         start_d_reg <= start_conf;
         wren        <= 1'b0;
         rden        <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE, ST_FAIL:
               if (start_edge) begin
                  phy_reg   <= '0;
                  idx_reg   <= '0;
                  retry_reg <= '0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  active    <= 1'b1;
               end
            ST_ISSUE_WR:
               if (!busy) begin
                  wren      <= 1'b1;
                  phy_add_o <= cur_phy;
                  reg_add   <= tbl_reg[idx_reg];
                  wr_data   <= tbl_data[idx_reg];
               end
            // Readback reuses the address/register still held from the write
            ST_ISSUE_RD:
               rden <= 1'b1;
            ST_WAIT_RD_DONE:
               if (!busy) rd_cap_reg <= rd_data;
            ST_CHECK:
               if (!rd_ok && (retry_reg < RTY_MAX)) retry_reg <= retry_reg + RTY_W'(1);
            ST_NEXT: begin
               retry_reg <= '0;
               if (last_entry) begin
                  done   <= 1'b1;
                  active <= 1'b0;
               end else if (idx_reg == IDX_LAST) begin
                  idx_reg <= '0;
                  phy_reg <= phy_reg + PHY_W'(1);
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            default: ;
         endcase
         if ((state_next == ST_FAIL) && (state_reg != ST_FAIL)) begin
            error   <= 1'b1;
            active  <= 1'b0;
            err_phy <= cur_phy;
            err_idx <= 8'(idx_reg);
         end
      end
   end

endmodule

// File: tb/tb_phy_conf_seq.sv
// Randomized bench for phy_conf_seq: an MDIO slave model with scheduled readback
// corruption, plus a table-level reference of the expected write sequence and outcome.
`timescale 1ns/1ps
module tb_phy_conf_seq;
   localparam int          NP     = 3;
   localparam int          NW     = 2;
   localparam int          MR     = 2;
   localparam int          TO     = 64;
   localparam logic [4:0]  BASE   = 5'h1E;
   localparam logic [9:0]  T_REG  = {5'h04, 5'h00};
   localparam logic [31:0] T_DATA = {16'h01E1, 16'h1100};
   localparam logic [31:0] T_MASK = {16'h0FFF, 16'hFFFF};

   logic        clk = 1'b0;
   logic        rst_n, start_conf, busy;
   logic [15:0] rd_data;
   logic [4:0]  phy_add_o, reg_add, err_phy;
   logic [15:0] wr_data;
   logic        wren, rden, active, done, error;
   logic [7:0]  err_idx;

   logic        start_l, busy_l;
   logic [15:0] rd_data_l;
   logic [4:0]  phy_add_o_l, reg_add_l, err_phy_l;
   logic [15:0] wr_data_l;
   logic        wren_l, rden_l, active_l, done_l, error_l;
   logic [7:0]  err_idx_l;

   always #5 clk = ~clk;

   phy_conf_seq #(
      .NUM_PHY(NP), .PHY_BASE(BASE), .NUM_WR(NW), .CFG_REG(T_REG), .CFG_DATA(T_DATA),
      .CFG_MASK(T_MASK), .VERIFY(1'b1), .MAX_RETRY(MR), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_conf(start_conf), .busy(busy), .rd_data(rd_data),
      .phy_add_o(phy_add_o), .reg_add(reg_add), .wr_data(wr_data), .wren(wren), .rden(rden),
      .active(active), .done(done), .error(error), .err_phy(err_phy), .err_idx(err_idx)
   );

   phy_conf_seq #(
      .NUM_PHY(1), .PHY_BASE(5'h0F), .NUM_WR(1), .CFG_REG(5'h00), .CFG_DATA(16'h1100),
      .CFG_MASK(16'hFFFF), .VERIFY(1'b0), .MAX_RETRY(3), .TIMEOUT(1024)
   ) dut_l (
      .clk(clk), .rst_n(rst_n), .start_conf(start_l), .busy(busy_l), .rd_data(rd_data_l),
      .phy_add_o(phy_add_o_l), .reg_add(reg_add_l), .wr_data(wr_data_l), .wren(wren_l),
      .rden(rden_l), .active(active_l), .done(done_l), .error(error_l), .err_phy(err_phy_l),
      .err_idx(err_idx_l)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [4:0] reg_of(input int i);
      logic [9:0] v;
      v = T_REG;
      return v[i*5 +: 5];
   endfunction
   function automatic logic [15:0] data_of(input int i);
      logic [31:0] v;
      v = T_DATA;
      return v[i*16 +: 16];
   endfunction
   function automatic logic [15:0] mask_of(input int i);
      logic [31:0] v;
      v = T_MASK;
      return v[i*16 +: 16];
   endfunction
   function automatic int phy_idx(input logic [4:0] pa);
      logic [4:0] d;
      d = pa - BASE;
      return int'(d);
   endfunction
   function automatic int reg_idx(input logic [4:0] ra);
      for (int i = 0; i < NW; i++) if (reg_of(i) == ra) return i;
      return -1;
   endfunction
   function automatic logic [15:0] clean_rd(input int e);
      return data_of(e) ^ (16'($urandom) & ~mask_of(e));
   endfunction
   function automatic logic [15:0] corrupt_rd(input int e);
      logic [15:0] m;
      int b;
      m = mask_of(e);
      b = $urandom_range(0, 15);
      while (!m[b]) b = (b + 1) % 16;
      return data_of(e) ^ (16'(1) << b);
   endfunction

   // MDIO slave model for the main instance
   logic [25:0] wr_log [$];
   int rd_cnt = 0;
   int rd_seen [NP][NW];
   int rd_base [NP][NW];
   int bad     [NP][NW];
   bit no_ack = 1'b0;
   bit both_seen = 1'b0;
   int busy_cnt, p_m, e_m;

   always @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         busy_cnt <= 0;
      end else begin
         if (wren && rden) both_seen <= 1'b1;
         if (wren) begin
            wr_log.push_back({phy_add_o, reg_add, wr_data});
            if (!no_ack) begin
               busy     <= 1'b1;
               busy_cnt <= $urandom_range(1, 6);
            end
         end else if (rden) begin
            p_m = phy_idx(phy_add_o);
            e_m = reg_idx(reg_add);
            if (p_m < NP && e_m >= 0) begin
               rd_data <= (rd_seen[p_m][e_m] - rd_base[p_m][e_m] < bad[p_m][e_m]) ?
                          corrupt_rd(e_m) : clean_rd(e_m);
               rd_seen[p_m][e_m] <= rd_seen[p_m][e_m] + 1;
            end else begin
               rd_data <= 16'hDEAD;
            end
            rd_cnt   <= rd_cnt + 1;
            busy     <= 1'b1;
            busy_cnt <= $urandom_range(1, 6);
         end else if (busy) begin
            if (busy_cnt <= 1) busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   // Fixed-latency MDIO model for the latency instance
   int lat_b = 1;
   int busy_cnt_l;
   int wren_l_cnt = 0;
   int rden_l_cnt = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         busy_l     <= 1'b0;
         busy_cnt_l <= 0;
      end else begin
         if (wren_l) begin
            wren_l_cnt <= wren_l_cnt + 1;
            busy_l     <= 1'b1;
            busy_cnt_l <= lat_b;
         end else if (busy_l) begin
            if (busy_cnt_l <= 1) busy_l <= 1'b0;
            busy_cnt_l <= busy_cnt_l - 1;
         end
         if (rden_l) rden_l_cnt <= rden_l_cnt + 1;
      end
   end

   // Reference: expected write sequence and outcome derived from the table and bad-read schedule
   logic [25:0] exp_wr [$];
   int          exp_rd;
   bit          exp_fail;
   logic [4:0]  exp_err_phy;
   logic [7:0]  exp_err_idx;

   task automatic build_expect();
      int att;
      exp_wr.delete();
      exp_rd = 0;
      exp_fail = 1'b0;
      exp_err_phy = '0;
      exp_err_idx = '0;
      for (int p = 0; p < NP; p++)
         for (int i = 0; i < NW; i++)
            if (!exp_fail) begin
               att = (bad[p][i] > MR) ? MR + 1 : bad[p][i] + 1;
               repeat (att) exp_wr.push_back({BASE + 5'(p), reg_of(i), data_of(i)});
               exp_rd += att;
               if (bad[p][i] > MR) begin
                  exp_fail    = 1'b1;
                  exp_err_phy = BASE + 5'(p);
                  exp_err_idx = 8'(i);
               end
            end
   endtask

   task automatic run_and_check(input string name, input bit toggle_start);
      int wr0, rd0, cyc, n;
      bit fin;
      build_expect();
      wr0 = wr_log.size();
      rd0 = rd_cnt;
      rd_base = rd_seen;
      @(negedge clk) start_conf = 1'b1;
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (toggle_start && cyc == 10 && active) start_conf = 1'b0;
         if (toggle_start && cyc == 12 && active) start_conf = 1'b1;
         fin = done || error;
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s completion: got none within %0d cycles, need done or error", name, cyc);
      end
      checks++;
      if ({done, error, active} !== {!exp_fail, exp_fail, 1'b0}) begin
         errors++;
         $display("FAIL %s status done/error/active: got %b%b%b need %b%b0", name, done, error, active, !exp_fail, exp_fail);
      end
      if (exp_fail) begin
         checks++;
         if ({err_phy, err_idx} !== {exp_err_phy, exp_err_idx}) begin
            errors++;
            $display("FAIL %s err_phy/err_idx: got %h/%0d need %h/%0d", name, err_phy, err_idx, exp_err_phy, exp_err_idx);
         end
      end
      n = wr_log.size() - wr0;
      checks++;
      if (n != exp_wr.size()) begin
         errors++;
         $display("FAIL %s write count: got %0d need %0d", name, n, exp_wr.size());
      end
      for (int k = 0; k < n && k < exp_wr.size(); k++) begin
         checks++;
         if (wr_log[wr0 + k] !== exp_wr[k]) begin
            errors++;
            $display("FAIL %s write %0d phy/reg/data: got %h/%h/%h need %h/%h/%h", name, k,
                     wr_log[wr0+k][25:21], wr_log[wr0+k][20:16], wr_log[wr0+k][15:0],
                     exp_wr[k][25:21], exp_wr[k][20:16], exp_wr[k][15:0]);
         end
      end
      checks++;
      if (rd_cnt - rd0 != exp_rd) begin
         errors++;
         $display("FAIL %s read count: got %0d need %0d", name, rd_cnt - rd0, exp_rd);
      end
      checks++;
      if (both_seen !== 1'b0) begin
         errors++;
         $display("FAIL %s wren_rden_overlap: got 1 need 0", name);
      end
      $display("run %-12s writes=%0d reads=%0d done=%0b error=%0b cycles=%0d", name, n, rd_cnt - rd0, done, error, cyc);
      @(negedge clk) start_conf = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_bad();
      for (int p = 0; p < NP; p++) for (int i = 0; i < NW; i++) bad[p][i] = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_conf = 1'b0;
      start_l = 1'b0;
      rd_data_l = 16'h0000;
      clear_bad();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({active, done, error, wren, rden} !== 5'b0) begin
         errors++;
         $display("FAIL reset control: got %b need 00000", {active, done, error, wren, rden});
      end
      checks++;
      if ({phy_add_o, reg_add, wr_data} !== 26'h0) begin
         errors++;
         $display("FAIL reset mdio outputs: got %h need 0", {phy_add_o, reg_add, wr_data});
      end
      checks++;
      if ({err_phy, err_idx} !== 13'h0) begin
         errors++;
         $display("FAIL reset err outputs: got %h need 0", {err_phy, err_idx});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({active, wren, active_l, wren_l} !== 4'b0) begin
         errors++;
         $display("FAIL idle without start: got %b need 0000", {active, wren, active_l, wren_l});
      end
      $display("test_reset done");
   endtask

   task automatic test_latency();
      int lat_tab [3];
      int n, w0;
      lat_tab[0] = 1; lat_tab[1] = 4; lat_tab[2] = 9;
      for (int k = 0; k < 3; k++) begin
         lat_b = lat_tab[k];
         w0 = wren_l_cnt;
         @(negedge clk) start_l = 1'b1;
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!done_l && n < 200);
         checks++;
         if (n != lat_tab[k] + 5) begin
            errors++;
            $display("FAIL latency busy=%0d: got %0d cycles need %0d", lat_tab[k], n, lat_tab[k] + 5);
         end
         checks++;
         if ({wren_l_cnt - w0, phy_add_o_l, reg_add_l, wr_data_l, error_l} !== {32'd1, 5'h0F, 5'h00, 16'h1100, 1'b0}) begin
            errors++;
            $display("FAIL latency write: got n=%0d %h/%h/%h err=%b need 1 0f/00/1100 0",
                     wren_l_cnt - w0, phy_add_o_l, reg_add_l, wr_data_l, error_l);
         end
         $display("latency busy=%0d cycles=%0d", lat_tab[k], n);
         @(negedge clk) start_l = 1'b0;
      end
      checks++;
      if (rden_l_cnt != 0) begin
         errors++;
         $display("FAIL no_verify reads: got %0d need 0", rden_l_cnt);
      end
   endtask

   task automatic test_clean_run();
      clear_bad();
      run_and_check("clean", 1'b1);
   endtask

   task automatic test_retry_exhaust();
      clear_bad();
      bad[0][1] = 1;
      bad[1][0] = MR;
      bad[1][1] = MR + 1;
      run_and_check("exhaust", 1'b0);
   endtask

   task automatic test_random_retries();
      for (int r = 0; r < 6; r++) begin
         for (int p = 0; p < NP; p++)
            for (int i = 0; i < NW; i++)
               bad[p][i] = ($urandom_range(0, 7) == 0) ? MR + 1 : $urandom_range(0, MR);
         run_and_check($sformatf("random%0d", r), r[0]);
      end
   endtask

   task automatic test_timeout();
      int n, wr0;
      bit found;
      clear_bad();
      no_ack = 1'b1;
      wr0 = wr_log.size();
      @(negedge clk) start_conf = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(posedge clk); #1;
         found = wren;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL timeout wren: got none need one");
      end
      n = 0;
      while (!error && n < 4 * TO) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != TO) begin
         errors++;
         $display("FAIL timeout cycles: got %0d need %0d", n, TO);
      end
      checks++;
      if ({err_phy, err_idx, done, active, 32'(wr_log.size() - wr0)} !== {BASE, 8'd0, 2'b00, 32'd1}) begin
         errors++;
         $display("FAIL timeout status: got phy=%h idx=%0d done=%b active=%b writes=%0d need %h 0 0 0 1",
                  err_phy, err_idx, done, active, wr_log.size() - wr0, BASE);
      end
      $display("timeout after %0d cycles err_phy=%h err_idx=%0d", n, err_phy, err_idx);
      no_ack = 1'b0;
      @(negedge clk) start_conf = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit found;
      clear_bad();
      @(negedge clk) start_conf = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(posedge clk); #1;
         found = wren;
      end
      @(posedge clk); #1;
      checks++;
      if (!found || !busy || !active) begin
         errors++;
         $display("FAIL midrun setup: got wren_seen=%b busy=%b active=%b need 111", found, busy, active);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({active, done, error, wren, rden, phy_add_o, reg_add, wr_data, err_phy, err_idx} !== 44'h0) begin
         errors++;
         $display("FAIL async reset outputs: got %h need 0",
                  {active, done, error, wren, rden, phy_add_o, reg_add, wr_data, err_phy, err_idx});
      end
      start_conf = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_and_check("after_reset", 1'b0);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_clean_run();
      test_retry_exhaust();
      test_random_retries();
      test_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
